// File: rtl/temp_sensor_spi_reader_pkg.sv
// Shared definitions for the MAX6630 SPI reader: FSM state encoding and SO word field positions.
package temp_sensor_spi_reader_pkg;

  localparam int TEMP_MSB = 15;
  localparam int TEMP_LSB = 3;
  localparam int ERR_BIT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SCK_LOW  = 3'd2,
    ST_SCK_HIGH = 3'd3,
    ST_CS_HIGH  = 3'd4
  } tsr_state_e;

endpackage

// File: rtl/temp_sensor_spi_reader_sck_gen.sv
// SCK half-period generator: while enabled, toggles SCK every C_SCK_HALF_CYC clocks and flags the
// cycle before each edge so the FSM can act on the same clock edge that moves SCK.
module temp_sensor_spi_reader_sck_gen #(
  parameter int C_SCK_HALF_CYC = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb,
  output logic sck
);

  localparam int CW = $clog2(C_SCK_HALF_CYC + 1);

  logic [CW-1:0] cnt;
  logic          half_done;

  assign half_done = en && (cnt == CW'(C_SCK_HALF_CYC - 1));
  assign rise_stb  = half_done && !sck;
  assign fall_stb  = half_done && sck;

  // Disabling returns SCK low with a fresh count, so every frame starts from a full low half period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (half_done) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/temp_sensor_spi_reader.sv
// SPI read master for the MAX6630: frames CS/SCK, shifts in the 16-bit SO word and presents the
// 13-bit signed temperature with a one-cycle valid strobe. Define TEMP_SENSOR_ALARM_EN for the alarm.
module temp_sensor_spi_reader
  import temp_sensor_spi_reader_pkg::*;
#(
  parameter int                 C_TEMP_SENSOR_PO_WL   = 16,
  parameter int                 C_TEMP_SENSOR_DATA_WL = 13,
  parameter int                 C_SCK_HALF_CYC        = 8,
  parameter int                 C_CS_SETUP_CYC        = 8,
  parameter int                 C_CS_HIGH_CYC         = 16,
  parameter int                 C_CONV_PERIOD_CYC     = 1000000,
  parameter logic signed [12:0] C_ALARM_HI            = 13'h0320,
  parameter logic signed [12:0] C_ALARM_LO            = 13'h02D0
) (
  input  logic                             Clk_IN,
  input  logic                             Reset_n_IN,
  input  logic                             Start_IN,
  input  logic                             Temp_sensor_SO_IN,
  output logic                             Temp_sensor_CS_OUT,
  output logic                             Temp_sensor_SCK_OUT,
  output logic [C_TEMP_SENSOR_DATA_WL-1:0] Temp_Data_OUT,
  output logic                             Data_Valid_OUT,
  output logic                             Sensor_Err_OUT,
  output logic                             Busy_OUT,
  output logic                             Alarm_OUT,
  output logic [2:0]                       Fsm_State_OUT
);

  localparam bit          PER_EN     = (C_CONV_PERIOD_CYC != 0);
  localparam logic [31:0] PER_RELOAD = PER_EN ? 32'(C_CONV_PERIOD_CYC - 1) : 32'd0;

  tsr_state_e                     state, state_d;
  logic [15:0]                    phase_cnt;
  logic [5:0]                     bit_cnt;
  logic [C_TEMP_SENSOR_PO_WL-1:0] shift_reg;
  logic [31:0]                    per_cnt;
  logic                           per_tick, trigger, pending;
  logic                           sck_en, rise_stb, fall_stb, load;

  assign per_tick      = PER_EN && (per_cnt == 32'd0);
  assign trigger       = Start_IN | per_tick;
  assign sck_en        = (state == ST_SCK_LOW) || (state == ST_SCK_HIGH);
  assign load          = (state == ST_CS_HIGH) && (phase_cnt == 16'd0);
  assign Fsm_State_OUT = state;

  temp_sensor_spi_reader_sck_gen #(.C_SCK_HALF_CYC(C_SCK_HALF_CYC)) u_sck_gen (
    .clk      (Clk_IN),
    .rst_n    (Reset_n_IN),
    .en       (sck_en),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .sck      (Temp_sensor_SCK_OUT)
  );

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:     if (trigger || pending) state_d = ST_CS_SETUP;
      ST_CS_SETUP: if (phase_cnt == 16'(C_CS_SETUP_CYC - 1)) state_d = ST_SCK_LOW;
      ST_SCK_LOW:  if (rise_stb) state_d = ST_SCK_HIGH;
      ST_SCK_HIGH: if (fall_stb)
                     state_d = (bit_cnt == 6'(C_TEMP_SENSOR_PO_WL)) ? ST_CS_HIGH : ST_SCK_LOW;
      ST_CS_HIGH:  if (phase_cnt == 16'(C_CS_HIGH_CYC - 1)) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_IN or negedge Reset_n_IN) begin
    if (!Reset_n_IN) begin
      state              <= ST_IDLE;
      phase_cnt          <= '0;
      bit_cnt            <= '0;
      shift_reg          <= '0;
      pending            <= 1'b0;
      per_cnt            <= PER_RELOAD;
      Temp_sensor_CS_OUT <= 1'b1;
      Busy_OUT           <= 1'b0;
      Temp_Data_OUT      <= '0;
      Sensor_Err_OUT     <= 1'b0;
      Data_Valid_OUT     <= 1'b0;
    end else begin
      state     <= state_d;
      phase_cnt <= (state_d != state) ? 16'd0 : phase_cnt + 16'd1;
      per_cnt   <= (per_cnt == 32'd0) ? PER_RELOAD : per_cnt - 32'd1;

      if (state == ST_IDLE) bit_cnt <= '0;
      else if (rise_stb)    bit_cnt <= bit_cnt + 6'd1;

      // SO is sampled on the clock edge that raises SCK; the sensor updates SO after SCK falls.
      if (rise_stb) shift_reg <= {shift_reg[C_TEMP_SENSOR_PO_WL-2:0], Temp_sensor_SO_IN};

      // A launch from IDLE consumes the request; anything arriving during a frame merges into one.
      if (state == ST_IDLE) pending <= 1'b0;
      else if (trigger)     pending <= 1'b1;

      if (state == ST_IDLE && state_d == ST_CS_SETUP) begin
        Temp_sensor_CS_OUT <= 1'b0;
        Busy_OUT           <= 1'b1;
      end
      if (state == ST_SCK_HIGH && state_d == ST_CS_HIGH) Temp_sensor_CS_OUT <= 1'b1;
      if (state == ST_CS_HIGH && state_d == ST_IDLE)     Busy_OUT <= 1'b0;

      Data_Valid_OUT <= load;
      if (load) begin
        Temp_Data_OUT  <= shift_reg[TEMP_MSB:TEMP_LSB];
        Sensor_Err_OUT <= shift_reg[ERR_BIT];
      end
    end
  end

`ifdef TEMP_SENSOR_ALARM_EN
  logic signed [12:0] new_temp;
  logic               alarm;

  assign new_temp  = shift_reg[TEMP_MSB:TEMP_LSB];
  assign Alarm_OUT = alarm;

  // Hysteresis between the set and clear thresholds; error samples never move the alarm.
  always_ff @(posedge Clk_IN or negedge Reset_n_IN) begin
    if (!Reset_n_IN) begin
      alarm <= 1'b0;
    end else if (load && !shift_reg[ERR_BIT]) begin
      if (new_temp >= C_ALARM_HI)      alarm <= 1'b1;
      else if (new_temp <= C_ALARM_LO) alarm <= 1'b0;
    end
  end
`else
  assign Alarm_OUT = 1'b0;
`endif

endmodule
